// File: rtl/fc_argmax_if.sv
// Score-stream and result signals between an FC-layer producer and the argmax stage.
// The master drives the score stream; the slave (fc_argmax) drives the result.
interface fc_argmax_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
);
    logic                     start;
    logic signed [DATA_W-1:0] in_data;
    logic                     valid_in;
    logic                     busy;
    logic        [IDX_W-1:0]  class_idx;
    logic signed [DATA_W-1:0] max_score;
    logic                     valid_out;
    logic                     done;
    logic                     drop_err;

    modport master (
        output start, in_data, valid_in,
        input  busy, class_idx, max_score, valid_out, done, drop_err
    );

    modport slave (
        input  start, in_data, valid_in,
        output busy, class_idx, max_score, valid_out, done, drop_err
    );
endinterface

// File: rtl/fc_argmax.sv
// Streaming argmax over NUM_CLASSES signed FC scores; reports the winning class
// index and score with a one-cycle valid_out/done pulse.
module fc_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16,
    parameter int IDX_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    fc_argmax_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2
    } state_t;

    // One extra bit so the counter can never wrap before the last score is seen.
    localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(NUM_CLASSES - 1);

    state_t                   state_reg;
    logic        [IDX_W:0]    count_reg;
    logic signed [DATA_W-1:0] best_score_reg;
    logic        [IDX_W-1:0]  best_idx_reg;
    logic        [IDX_W-1:0]  class_idx_reg;
    logic signed [DATA_W-1:0] max_score_reg;
    logic                     busy_reg;
    logic                     valid_out_reg;
    logic                     done_reg;
    logic                     drop_err_reg;

    logic                     take_next;
    logic                     last_score;
    logic signed [DATA_W-1:0] best_score_next;
    logic        [IDX_W-1:0]  best_idx_next;

    // First score loads unconditionally, so the most negative value needs no sentinel.
    always_comb begin
        take_next       = 1'b0;
        last_score      = 1'b0;
        best_score_next = best_score_reg;
        best_idx_next   = best_idx_reg;
        take_next       = (count_reg == '0) || (bus.in_data > best_score_reg);
        last_score      = (count_reg == LAST_IDX);
        if (take_next) begin
            best_score_next = bus.in_data;
            best_idx_next   = count_reg[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            best_score_reg <= '0;
            best_idx_reg   <= '0;
            class_idx_reg  <= '0;
            max_score_reg  <= '0;
            busy_reg       <= 1'b0;
            valid_out_reg  <= 1'b0;
            done_reg       <= 1'b0;
            drop_err_reg   <= 1'b0;
        end else begin
            valid_out_reg <= 1'b0;
            done_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg    <= COLLECT;
                        count_reg    <= '0;
                        busy_reg     <= 1'b1;
                        drop_err_reg <= 1'b0;
                    end else if (bus.valid_in) begin
                        drop_err_reg <= 1'b1;
                    end
                end
                COLLECT: begin
                    // A restart wins over a score arriving in the same cycle.
                    if (bus.start) begin
                        count_reg <= '0;
                    end else if (bus.valid_in) begin
                        best_score_reg <= best_score_next;
                        best_idx_reg   <= best_idx_next;
                        count_reg      <= count_reg + 1'b1;
                        if (last_score) begin
                            state_reg     <= RESULT;
                            busy_reg      <= 1'b0;
                            valid_out_reg <= 1'b1;
                            done_reg      <= 1'b1;
                            class_idx_reg <= best_idx_next;
                            max_score_reg <= best_score_next;
                        end
                    end
                end
                RESULT: begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                    if (bus.valid_in) begin
                        drop_err_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.class_idx = class_idx_reg;
    assign bus.max_score = max_score_reg;
    assign bus.valid_out = valid_out_reg;
    assign bus.done      = done_reg;
    assign bus.drop_err  = drop_err_reg;

endmodule

// File: tb/tb_fc_argmax.sv
// Randomised and directed checks of fc_argmax against a plain argmax reference,
// with a queue-based scoreboard popped by an independent result monitor.
module tb_fc_argmax;
    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 16;
    localparam int IDX_W       = 4;

    typedef struct {
        int idx;
        int score;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fc_argmax_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    fc_argmax #(
        .NUM_CLASSES (NUM_CLASSES),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks    = 0;
    int   failures  = 0;
    int   vo_count  = 0;
    exp_t exp_q[$];
    exp_t last_exp;
    logic signed [DATA_W-1:0] sc [NUM_CLASSES];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Result monitor: every valid_out must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.valid_out || bus.done)) begin
            check("done_eq_valid_out", int'(bus.done), int'(bus.valid_out));
            check("busy_low_at_result", int'(bus.busy), 0);
            vo_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid_out actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                check("class_idx", int'(bus.class_idx), e.idx);
                check("max_score", int'(bus.max_score), e.score);
                $display("txn result class_idx=%0d max_score=%0d expected=%0d/%0d",
                         bus.class_idx, bus.max_score, e.idx, e.score);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t ref_argmax();
        exp_t e;
        e.idx   = 0;
        e.score = int'(sc[0]);
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (int'(sc[i]) > e.score) begin
                e.idx   = i;
                e.score = int'(sc[i]);
            end
        end
        return e;
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
        check("drop_err_cleared_by_start", int'(bus.drop_err), 0);
    endtask

    task automatic send_score(input logic signed [DATA_W-1:0] v, input int gap);
        bus.valid_in = 1'b0;
        for (int g = 0; g < gap; g++) begin
            step();
            check("busy_during_gap", int'(bus.busy), 1);
        end
        bus.valid_in = 1'b1;
        bus.in_data  = v;
        @(negedge clk);
        check("busy_during_collect", int'(bus.busy), 1);
        step();
        bus.valid_in = 1'b0;
    endtask

    task automatic run_inference(input int maxgap, input bit abort_first, input bit poke_result);
        exp_t e;
        int   vo_before;
        int   n;
        e         = ref_argmax();
        vo_before = vo_count;
        exp_q.push_back(e);
        $display("txn issue expected class_idx=%0d max_score=%0d", e.idx, e.score);
        pulse_start();
        if (abort_first) begin
            send_score(16'sd10, 0);
            send_score(16'sd20, 0);
            send_score(16'sd30, 0);
            send_score(16'sd1000, 0);
            bus.start    = 1'b1;
            bus.valid_in = 1'b1;
            bus.in_data  = 16'sd32767;
            step();
            bus.start    = 1'b0;
            bus.valid_in = 1'b0;
            check("busy_after_restart", int'(bus.busy), 1);
        end
        for (int i = 0; i < NUM_CLASSES; i++) begin
            send_score(sc[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
        if (poke_result) begin
            // Now in the result cycle: start must be ignored, valid_in must flag a drop.
            bus.start    = 1'b1;
            bus.valid_in = 1'b1;
            step();
            bus.start    = 1'b0;
            bus.valid_in = 1'b0;
            check("start_ignored_in_result", int'(bus.busy), 0);
            check("drop_err_in_result", int'(bus.drop_err), 1);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL result_timeout actual=none required=valid_out");
            exp_q.delete();
        end
        step();
        step();
        check("single_valid_out", vo_count - vo_before, 1);
        check("class_idx_hold", int'(bus.class_idx), e.idx);
        check("max_score_hold", int'(bus.max_score), e.score);
        last_exp = e;
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.valid_in = 1'b0;
        bus.in_data  = '0;
        #12;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_valid_out", int'(bus.valid_out), 0);
        check("reset_drop_err", int'(bus.drop_err), 0);
        check("reset_class_idx", int'(bus.class_idx), 0);
        check("reset_max_score", int'(bus.max_score), 0);
        step();
        rst = 1'b0;

        // Mixed scores with a tie at the maximum: lower index wins.
        sc = '{16'sd5, -16'sd3, 16'sd100, 16'sd7, 16'sd100, 16'sd0, -16'sd8, 16'sd2, 16'sd99, 16'sd1};
        run_inference(0, 1'b0, 1'b0);

        // All scores at the most negative value.
        for (int i = 0; i < NUM_CLASSES; i++) sc[i] = 16'sh8000;
        run_inference(0, 1'b0, 1'b0);

        // Ascending scores with random gaps.
        for (int i = 0; i < NUM_CLASSES; i++) sc[i] = DATA_W'(i + 1);
        run_inference(3, 1'b0, 1'b1);

        // Abort after four scores, then a full fresh inference.
        sc = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd50, 16'sd7, 16'sd8, 16'sd9};
        run_inference(0, 1'b1, 1'b0);

        // Random inferences; odd iterations use a narrow range to force ties.
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (t % 2 == 1) sc[i] = DATA_W'(int'($urandom_range(0, 6)) - 3);
                else            sc[i] = DATA_W'($urandom);
            end
            run_inference(t % 4, 1'b0, (t % 3) == 0);
        end

        // Reset mid-collection discards the partial inference.
        begin
            int vo_before;
            vo_before = vo_count;
            pulse_start();
            for (int i = 0; i < 5; i++) send_score(DATA_W'(i * 7 + 1), 0);
            #2;
            rst = 1'b1;
            #1;
            check("async_rst_busy", int'(bus.busy), 0);
            check("async_rst_valid_out", int'(bus.valid_out), 0);
            check("async_rst_done", int'(bus.done), 0);
            check("async_rst_drop_err", int'(bus.drop_err), 0);
            check("async_rst_class_idx", int'(bus.class_idx), 0);
            check("async_rst_max_score", int'(bus.max_score), 0);
            step();
            step();
            rst = 1'b0;
            for (int i = 0; i < 8; i++) step();
            check("no_valid_out_after_reset", vo_count - vo_before, 0);
            bus.valid_in = 1'b1;
            bus.in_data  = 16'sd42;
            step();
            bus.valid_in = 1'b0;
            check("drop_err_in_idle", int'(bus.drop_err), 1);
            step();
            check("drop_err_sticky", int'(bus.drop_err), 1);
        end

        // Next inference clears drop_err on start and runs normally.
        for (int i = 0; i < NUM_CLASSES; i++) sc[i] = DATA_W'($urandom);
        run_inference(2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
